dmac_rr_arbiter: RTL and testbench

DMAC_RR_ARBITER -- requirements
Module: dmac_rr_arbiter

---
 rtl/dmac_arb_pkg.sv | 16 +
 rtl/dmac_arb_fifo.sv | 55 +++++
 rtl/dmac_rr_arbiter.sv | 128 ++++++++++++
 tb/tb_dmac_rr_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmac_arb_pkg.sv
// Shared types and sizing helpers for the DMA channel round-robin arbiter.
package dmac_arb_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

    localparam int FIFO_DEPTH = 2;

    // Width of a source index; never narrower than one bit.
    function automatic int id_width(input int n_master);
        return (n_master > 1) ? $clog2(n_master) : 1;
    endfunction

endpackage

// File: rtl/dmac_arb_fifo.sv
// Two-entry beat FIFO; head entry drives the output directly from storage registers.
module dmac_arb_fifo
    import dmac_arb_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic             push;
    logic             pop;

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign out_data  = mem[rd_ptr];
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // NOTE: storage is reset here because the head entry is a visible output that
    // must read zero after reset; with only two entries the cost is negligible.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dmac_rr_arbiter.sv
// Round-robin burst arbiter merging N_MASTER beat streams into one buffered stream.
// Optional macro DMAC_ARB_PRIORITY_EN adds src_prio_i to favour flagged sources.
module dmac_rr_arbiter
    import dmac_arb_pkg::*;
#(
    parameter  int N_MASTER  = 4,
    parameter  int DATA_SIZE = 32,
    localparam int ID_W      = id_width(N_MASTER)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [N_MASTER-1:0]             src_valid_i,
    output logic [N_MASTER-1:0]             src_ready_o,
    input  logic [N_MASTER*DATA_SIZE-1:0]   src_data_i,
    input  logic [N_MASTER-1:0]             src_last_i,
`ifdef DMAC_ARB_PRIORITY_EN
    input  logic [N_MASTER-1:0]             src_prio_i,
`endif
    output logic                            dst_valid_o,
    input  logic                            dst_ready_i,
    output logic [DATA_SIZE-1:0]            dst_data_o,
    output logic                            dst_last_o,
    output logic [ID_W-1:0]                 dst_id_o
);

    localparam int FIFO_W = DATA_SIZE + 1 + ID_W;

    arb_state_e          state;
    logic [ID_W-1:0]     grant;
    logic [ID_W-1:0]     last_grant;
    logic [N_MASTER-1:0] cand;
    logic [ID_W-1:0]     hi_win;
    logic [ID_W-1:0]     lo_win;
    logic                hi_hit;
    logic [ID_W-1:0]     winner;
    logic                any_req;

    logic                fifo_in_valid;
    logic                fifo_in_ready;
    logic [FIFO_W-1:0]   fifo_in_data;
    logic [FIFO_W-1:0]   fifo_out_data;
    logic                beat_xfer;
    logic                last_xfer;

    // Candidate set: prioritised sources when any of them request, else all requesters.
    always_comb begin
        cand = src_valid_i;
`ifdef DMAC_ARB_PRIORITY_EN
        if (|(src_valid_i & src_prio_i)) begin
            cand = src_valid_i & src_prio_i;
        end
`endif
    end

    assign any_req = |cand;

    // Lowest candidate above last_grant wins; otherwise the search wraps to the lowest overall.
    // NOTE: every signal assigned in this block gets a default first so no latch is inferred.
    always_comb begin
        hi_win = '0;
        lo_win = '0;
        hi_hit = 1'b0;
        for (int i = N_MASTER - 1; i >= 0; i--) begin
            if (cand[i]) begin
                lo_win = ID_W'(i);
                if (i > int'(last_grant)) begin
                    hi_win = ID_W'(i);
                    hi_hit = 1'b1;
                end
            end
        end
        winner = hi_hit ? hi_win : lo_win;
    end

    always_comb begin
        src_ready_o = '0;
        if (state == ST_LOCKED) begin
            src_ready_o[grant] = fifo_in_ready;
        end
    end

    assign fifo_in_valid = (state == ST_LOCKED) && src_valid_i[grant];
    assign fifo_in_data  = {src_data_i[int'(grant)*DATA_SIZE +: DATA_SIZE], src_last_i[grant], grant};
    assign beat_xfer     = fifo_in_valid && fifo_in_ready;
    assign last_xfer     = beat_xfer && src_last_i[grant];

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            grant      <= '0;
            last_grant <= ID_W'(N_MASTER - 1);
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        grant <= winner;
                        state <= ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    if (last_xfer) begin
                        last_grant <= grant;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    dmac_arb_fifo #(
        .WIDTH (FIFO_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (fifo_in_valid),
        .in_ready  (fifo_in_ready),
        .in_data   (fifo_in_data),
        .out_valid (dst_valid_o),
        .out_ready (dst_ready_i),
        .out_data  (fifo_out_data)
    );

    assign {dst_data_o, dst_last_o, dst_id_o} = fifo_out_data;

endmodule

// File: tb/tb_dmac_rr_arbiter.sv
// Directed bench for dmac_rr_arbiter: reset, fairness, burst lock, backpressure, mid-burst reset.
module tb_dmac_rr_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    src_valid_i = '0;
    logic [N-1:0]    src_ready_o;
    logic [N*DW-1:0] src_data_i = '0;
    logic [N-1:0]    src_last_i = '0;
`ifdef DMAC_ARB_PRIORITY_EN
    logic [N-1:0]    src_prio_i = '0;
`endif
    logic            dst_valid_o;
    logic            dst_ready_i = 1'b1;
    logic [DW-1:0]   dst_data_o;
    logic            dst_last_o;
    logic [IW-1:0]   dst_id_o;

    always #5 clk = ~clk;

    dmac_rr_arbiter #(
        .N_MASTER  (N),
        .DATA_SIZE (DW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .src_valid_i (src_valid_i),
        .src_ready_o (src_ready_o),
        .src_data_i  (src_data_i),
        .src_last_i  (src_last_i),
`ifdef DMAC_ARB_PRIORITY_EN
        .src_prio_i  (src_prio_i),
`endif
        .dst_valid_o (dst_valid_o),
        .dst_ready_i (dst_ready_i),
        .dst_data_o  (dst_data_o),
        .dst_last_o  (dst_last_o),
        .dst_id_o    (dst_id_o)
    );

    typedef struct packed {
        logic [IW-1:0] id;
        logic          last;
        logic [DW-1:0] data;
    } beat_t;

    int     checks   = 0;
    int     failures = 0;
    int     sent  [N];
    int     quota [N];
    int     blen  [N];
    logic [N-1:0] mute = '0;
    beat_t  q [$];

    function automatic logic [DW-1:0] mk(input int s, input int k);
        return 32'hA500_0000 + 32'(s * 256 + k);
    endfunction

    function automatic beat_t exp_beat(input int s, input int k, input logic last);
        beat_t b;
        b.id   = IW'(s);
        b.last = last;
        b.data = mk(s, k);
        return b;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Record every beat the sink accepts.
    always @(posedge clk) begin
        if (!rst && dst_valid_o && dst_ready_i) begin
            q.push_back(beat_t'{dst_id_o, dst_last_o, dst_data_o});
        end
    end

    task automatic load(input int s, input int qn, input int bl);
        sent[s]  = 0;
        quota[s] = qn;
        blen[s]  = bl;
        mute[s]  = 1'b0;
    endtask

    task automatic clear_all();
        for (int s = 0; s < N; s++) load(s, 0, 1);
    endtask

    task automatic drive();
        for (int s = 0; s < N; s++) begin
            src_valid_i[s]           = (sent[s] < quota[s]) && !mute[s];
            src_data_i[s*DW +: DW]   = mk(s, sent[s]);
            src_last_i[s]            = ((sent[s] + 1) % blen[s]) == 0;
        end
    endtask

    // One clock: drive sources, note which beats transfer at the edge, settle 1 time unit.
    task automatic step();
        logic [N-1:0] xfer;
        drive();
        xfer = src_valid_i & src_ready_o;
        @(posedge clk);
        for (int s = 0; s < N; s++) if (xfer[s]) sent[s]++;
        #1;
    endtask

    task automatic run_until(input int n, input int budget, input string tag);
        int c = 0;
        while (q.size() < n && c < budget) begin
            step();
            c++;
        end
        check({tag, "_count"}, 64'(q.size()), 64'(n));
    endtask

    task automatic check_beat(input string tag, input int i, input int s, input int k, input logic last);
        beat_t obs;
        obs = 'x;
        if (i < q.size()) obs = q[i];
        check(tag, 64'(obs), 64'(exp_beat(s, k, last)));
    endtask

    initial begin
        // Reset held two cycles with every source requesting.
        clear_all();
        for (int s = 0; s < N; s++) load(s, 1, 1);
        rst = 1'b1;
        step();
        check("rst1_ready", 64'(src_ready_o), 64'(0));
        check("rst1_dst", 64'({dst_valid_o, dst_last_o, dst_id_o}), 64'(0));
        check("rst1_data", 64'(dst_data_o), 64'(0));
        step();
        check("rst2_ready", 64'(src_ready_o), 64'(0));
        check("rst2_dst", 64'({dst_valid_o, dst_last_o, dst_id_o}), 64'(0));

        // Fairness with single-beat bursts; master 0 asks twice to exercise the wrap.
        load(0, 2, 1);
        q.delete();
        rst = 1'b0;
        step();
        check("first_grant", 64'(src_ready_o), 64'(4'b0001));
        step();
        check("latency_valid", 64'(dst_valid_o), 64'(1));
        check("latency_id", 64'(dst_id_o), 64'(0));
        check("idle_gap", 64'(src_ready_o), 64'(0));
        run_until(5, 40, "fair");
        check_beat("fair0", 0, 0, 0, 1'b1);
        check_beat("fair1", 1, 1, 0, 1'b1);
        check_beat("fair2", 2, 2, 0, 1'b1);
        check_beat("fair3", 3, 3, 0, 1'b1);
        check_beat("fair4", 4, 0, 1, 1'b1);

        // Burst lock: master 2 owns a 4-beat burst, drops valid mid-burst, master 1 waits.
        q.delete();
        clear_all();
        load(2, 4, 4);
        step();
        check("lock_grant", 64'(src_ready_o), 64'(4'b0100));
        load(1, 1, 1);
        step();
        step();
        mute[2] = 1'b1;
        step();
        check("lock_hold_a", 64'(src_ready_o), 64'(4'b0100));
        step();
        check("lock_hold_b", 64'(src_ready_o), 64'(4'b0100));
        mute[2] = 1'b0;
        run_until(5, 40, "lock");
        check_beat("lock0", 0, 2, 0, 1'b0);
        check_beat("lock1", 1, 2, 1, 1'b0);
        check_beat("lock2", 2, 2, 2, 1'b0);
        check_beat("lock3", 3, 2, 3, 1'b1);
        check_beat("lock4", 4, 1, 0, 1'b1);

        // Backpressure: sink stalls five cycles after the first beat is buffered.
        q.delete();
        clear_all();
        load(0, 4, 4);
        dst_ready_i = 1'b1;
        step();
        check("bp_grant", 64'(src_ready_o), 64'(4'b0001));
        step();
        dst_ready_i = 1'b0;
        step();
        check("bp_full_ready", 64'(src_ready_o), 64'(0));
        check("bp_head", 64'(dst_data_o), 64'(mk(0, 0)));
        for (int c = 0; c < 4; c++) begin
            step();
            check("bp_stall_ready", 64'(src_ready_o), 64'(0));
            check("bp_stall_data", 64'({dst_valid_o, dst_data_o}), 64'({1'b1, mk(0, 0)}));
        end
        check("bp_buffered", 64'(sent[0]), 64'(2));
        check("bp_no_pop", 64'(q.size()), 64'(0));
        dst_ready_i = 1'b1;
        run_until(4, 40, "bp");
        check_beat("bp0", 0, 0, 0, 1'b0);
        check_beat("bp1", 1, 0, 1, 1'b0);
        check_beat("bp2", 2, 0, 2, 1'b0);
        check_beat("bp3", 3, 0, 3, 1'b1);
        for (int c = 0; c < 3; c++) step();
        check("bp_no_dup", 64'(q.size()), 64'(4));

        // Mid-burst reset: master 3 wins, reset lands on its second beat.
        q.delete();
        clear_all();
        load(3, 4, 4);
        load(0, 1, 1);
        step();
        check("mr_grant", 64'(src_ready_o), 64'(4'b1000));
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mr_fifo_empty", 64'(dst_valid_o), 64'(0));
        check("mr_ready", 64'(src_ready_o), 64'(0));
        mute[3] = 1'b1;
        q.delete();
        step();
        check("mr_next_grant", 64'(src_ready_o), 64'(4'b0001));
        run_until(1, 20, "mr");
        check_beat("mr0", 0, 0, 0, 1'b1);
        for (int c = 0; c < 3; c++) step();
        check("mr_no_stale", 64'(q.size()), 64'(1));

`ifdef DMAC_ARB_PRIORITY_EN
        // Priority: master 3 flagged beats master 0 even though the pointer favours 0.
        q.delete();
        clear_all();
        rst = 1'b1;
        step();
        rst = 1'b0;
        load(0, 1, 1);
        load(3, 1, 1);
        src_prio_i = 4'b1000;
        step();
        check("prio_grant", 64'(src_ready_o), 64'(4'b1000));
        run_until(2, 30, "prio");
        check_beat("prio0", 0, 3, 0, 1'b1);
        check_beat("prio1", 1, 0, 0, 1'b1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
